// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Control-side sequencer for the ALU datapath. Accepts one
//             R-format instruction per valid/ready handshake, decodes the
//             opcode and steps the bus controls through
//             Y load -> ALU op strobe + Zin -> Z writeback (RF or LO/HI).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          rising-edge clock
//    clr_n_i        synchronous active-low reset
//    instr_valid_i  instr_i holds a valid instruction
//    instr_ready_o  sequencer idle and able to accept
//    instr_i        32-bit instruction word {op, ra, rb, rc, unused}
//    rf_rd_addr_o   register driven onto the bus
//    rf_rd_en_o     register file drives the bus
//    rf_wr_addr_o   destination register
//    rf_wr_en_o     write bus value into rf_wr_addr_o
//    y_in_o         load bus into Y
//    z_in_o         latch ALU result into ZLo/ZHi
//    zlo_out_o      ZLo drives the bus
//    zhi_out_o      ZHi drives the bus
//    lo_in_o        load bus into LO
//    hi_in_o        load bus into HI
//    alu_op_o       one-hot ALU operation strobe
//    done_o         one-cycle completion pulse
//    illegal_o      one-cycle unsupported-opcode pulse
// ============================================================================
module alu_op_sequencer #(
  parameter int OPCODE_W   = 5,
  parameter int REG_ADDR_W = 4,
  parameter int EXE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  clr_n_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [31:0]           instr_i,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
  output logic                  rf_rd_en_o,
  output logic [REG_ADDR_W-1:0] rf_wr_addr_o,
  output logic                  rf_wr_en_o,
  output logic                  y_in_o,
  output logic                  z_in_o,
  output logic                  zlo_out_o,
  output logic                  zhi_out_o,
  output logic                  lo_in_o,
  output logic                  hi_in_o,
  output logic [12:0]           alu_op_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  localparam int RA_MSB = 31 - OPCODE_W;
  localparam int RB_MSB = RA_MSB - REG_ADDR_W;
  localparam int RC_MSB = RB_MSB - REG_ADDR_W;
  localparam int LO_MSB = RC_MSB - REG_ADDR_W;

  localparam logic [3:0] EXE_LAST = 4'(EXE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_LDY  = 3'd2,
    S_EXE  = 3'd3,
    S_WBLO = 3'd4,
    S_WBHI = 3'd5
  } state_t;

  // Opcode -> one-hot ALU strobe; all-zero means unsupported.
  function automatic logic [12:0] op_onehot(input logic [OPCODE_W-1:0] op);
    logic [12:0] oh;
    oh = '0;
    case (op)
      OPCODE_W'(5'b00101): oh[0]  = 1'b1; // AND
      OPCODE_W'(5'b00110): oh[1]  = 1'b1; // OR
      OPCODE_W'(5'b10001): oh[2]  = 1'b1; // NEG
      OPCODE_W'(5'b10010): oh[3]  = 1'b1; // NOT
      OPCODE_W'(5'b00100): oh[4]  = 1'b1; // SUB
      OPCODE_W'(5'b00011): oh[5]  = 1'b1; // ADD
      OPCODE_W'(5'b10000): oh[6]  = 1'b1; // MUL
      OPCODE_W'(5'b00111): oh[7]  = 1'b1; // ROR
      OPCODE_W'(5'b01000): oh[8]  = 1'b1; // ROL
      OPCODE_W'(5'b01111): oh[9]  = 1'b1; // DIV
      OPCODE_W'(5'b01001): oh[10] = 1'b1; // SHR
      OPCODE_W'(5'b01011): oh[11] = 1'b1; // SHL
      OPCODE_W'(5'b01010): oh[12] = 1'b1; // SHRA
      default:             oh     = '0;
    endcase
    return oh;
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [REG_ADDR_W-1:0] ra_q, rb_q, rc_q;

  logic [12:0] oh_in;
  logic [12:0] oh_q;
  logic        accept;
  logic        unary_q;
  logic        muldiv_q;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instr_i[LO_MSB:0];

  assign oh_in    = op_onehot(instr_i[31 -: OPCODE_W]);
  assign oh_q     = op_onehot(opcode_q);
  assign unary_q  = oh_q[2] | oh_q[3];
  assign muldiv_q = oh_q[6] | oh_q[9];
  assign accept   = instr_valid_i && (state_q == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        opcode_q <= instr_i[31 -: OPCODE_W];
        ra_q     <= instr_i[RA_MSB -: REG_ADDR_W];
        rb_q     <= instr_i[RB_MSB -: REG_ADDR_W];
        rc_q     <= instr_i[RC_MSB -: REG_ADDR_W];
      end
    end
  end

  // Next state. Only the IDLE decision looks at the live instruction;
  // every output below is decoded from registered state alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          if (oh_in == '0)             state_d = S_ERR;
          else if (oh_in[2] | oh_in[3]) state_d = S_EXE;  // unary skips Y load
          else                         state_d = S_LDY;
        end
      end
      S_ERR:  state_d = S_IDLE;
      S_LDY:  state_d = S_EXE;
      S_EXE: begin
        if (cnt_q == EXE_LAST) begin
          cnt_d   = '0;
          state_d = S_WBLO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WBLO: state_d = muldiv_q ? S_WBHI : S_IDLE;
      S_WBHI: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready_o = 1'b0;
    rf_rd_addr_o  = '0;
    rf_rd_en_o    = 1'b0;
    rf_wr_addr_o  = '0;
    rf_wr_en_o    = 1'b0;
    y_in_o        = 1'b0;
    z_in_o        = 1'b0;
    zlo_out_o     = 1'b0;
    zhi_out_o     = 1'b0;
    lo_in_o       = 1'b0;
    hi_in_o       = 1'b0;
    alu_op_o      = '0;
    done_o        = 1'b0;
    illegal_o     = 1'b0;
    case (state_q)
      S_IDLE: instr_ready_o = 1'b1;
      S_ERR:  illegal_o     = 1'b1;
      S_LDY: begin
        rf_rd_addr_o = rb_q;
        rf_rd_en_o   = 1'b1;
        y_in_o       = 1'b1;
      end
      S_EXE: begin
        // Binary ops put rc on the bus (Y already holds rb); unary ops use rb.
        rf_rd_addr_o = unary_q ? rb_q : rc_q;
        rf_rd_en_o   = 1'b1;
        alu_op_o     = oh_q;
        z_in_o       = 1'b1;
      end
      S_WBLO: begin
        zlo_out_o = 1'b1;
        if (muldiv_q) begin
          lo_in_o = 1'b1;
        end else begin
          rf_wr_addr_o = ra_q;
          rf_wr_en_o   = 1'b1;
          done_o       = 1'b1;
        end
      end
      S_WBHI: begin
        zhi_out_o = 1'b1;
        hi_in_o   = 1'b1;
        done_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
